seq_detect_param: RTL

- Parametrised serial sequence detector: successor to the fixed 4-bit "0101" Moore detector.
- Samples one bit per qualified cycle and compares the last PAT_W bits against a pattern register that can be loaded at run time.
- Emits a registered one-cycle match pulse and keeps a saturating match count.
- Supports both overlapping and non-overlapping match modes; used as a reusable lab/system block wherever serial pattern detection is needed.

---
 rtl/seq_detect_pkg.sv | 20 ++
 rtl/seq_detect_param_sat_counter.sv | 42 ++++
 rtl/seq_detect_param.sv | 98 +++++++++
 3 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the parametrised serial sequence detector.
package seq_detect_pkg;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } state_e;

  // Increment that sticks at the all-ones value of a w-bit counter (w <= 31).
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned w);
    logic [31:0] max_v;
    max_v = (32'd1 << w) - 32'd1;
    if (val >= max_v) begin
      return max_v;
    end else begin
      return val + 32'd1;
    end
  endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating event counter; clear and increment together leave the count at one.
module sat_counter
  import seq_detect_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count
  always_comb begin
    cnt_d = cnt_q;
    if (clr && inc) begin
      cnt_d = CNT_W'(1);
    end else if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_W));
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector: compares the last PAT_W valid bits with a loadable
// pattern, pulses dataout one cycle after a match and counts matches.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W       = 4,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(4'b0101),
  parameter int               CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ina,
  input  logic             in_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             dataout,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  localparam int                FILL_W   = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  state_e            state_q, state_d;
  logic              dataout_q, dataout_d;
  logic [PAT_W-1:0]  cand_s;
  logic              hit_s;

  assign cand_s = {hist_q, ina};
  assign hit_s  = in_valid & (state_q == ST_ARMED) & (cand_s == pat_q) & ~pat_load;

  // history, fill, pattern and FSM next state
  always_comb begin
    pat_d     = pat_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    state_d   = state_q;
    dataout_d = hit_s;
    if (pat_load) begin
      // a bit presented alongside a load is dropped on purpose
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      if (hit_s && !overlap) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = cand_s[PAT_W-2:0];
        fill_d = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + FILL_W'(1);
      end
    end else begin
      hist_d = hist_q;
      fill_d = fill_q;
    end
    case (state_q)
      ST_FILL:  state_d = (fill_d == FILL_MAX) ? ST_ARMED : ST_FILL;
      ST_ARMED: state_d = (fill_d == FILL_MAX) ? ST_ARMED : ST_FILL;
      default:  state_d = ST_FILL;
    endcase
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q     <= DEFAULT_PAT;
      hist_q    <= '0;
      fill_q    <= '0;
      state_q   <= ST_FILL;
      dataout_q <= 1'b0;
    end else begin
      pat_q     <= pat_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      state_q   <= state_d;
      dataout_q <= dataout_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(hit_s),
    .clr(cnt_clr),
    .cnt(match_cnt)
  );

  assign dataout = dataout_q;
  assign armed   = (state_q == ST_ARMED);

endmodule
